// File: rtl/dm_cache_ctrl_pkg.sv
// Shared types and constants for the direct-mapped cache controller.
// Package cache_def: CPU/memory/array bus payloads, address split constants,
// controller state enum and line word helpers.
package cache_def;

  localparam int unsigned TAGMSB  = 31;
  localparam int unsigned TAGLSB  = 14;
  localparam int unsigned TAG_W   = TAGMSB - TAGLSB + 1;
  localparam int unsigned IDX_MSB = 13;
  localparam int unsigned IDX_LSB = 4;
  localparam int unsigned IDX_W   = IDX_MSB - IDX_LSB + 1;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned LINE_W  = 128;
  localparam int unsigned CNT_W   = 32;

  typedef logic [LINE_W-1:0] cache_data_type;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } cache_tag_type;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic             we;
  } cache_req_type;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    logic        valid;
  } cpu_req_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } cpu_result_type;

  typedef struct packed {
    logic [31:0]    addr;
    cache_data_type data;
    logic           rw;
    logic           valid;
  } mem_req_type;

  typedef struct packed {
    cache_data_type data;
    logic           ready;
  } mem_data_type;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    COMPARE_TAG = 2'd1,
    ALLOCATE    = 2'd2,
    WRITE_BACK  = 2'd3
  } cache_state_type;

  // Extract one 32-bit word from a line.
  function automatic logic [WORD_W-1:0] get_word(input cache_data_type line, input logic [1:0] sel);
    return line[{sel, 5'b0} +: WORD_W];
  endfunction

  // Return the line with one 32-bit word replaced.
  function automatic cache_data_type put_word(input cache_data_type line, input logic [1:0] sel,
                                              input logic [WORD_W-1:0] w);
    cache_data_type l;
    l = line;
    l[{sel, 5'b0} +: WORD_W] = w;
    return l;
  endfunction

endpackage

// File: rtl/dm_cache_stats.sv
// Hit / miss / write-back event counters for the cache controller.
// Ports: clk, rst_n; hit_i, miss_i, wb_i single-cycle event strobes;
// hit_cnt_o, miss_cnt_o, wb_cnt_o free-running wrapping counts.
module dm_cache_stats
  import cache_def::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hit_i,
  input  logic             miss_i,
  input  logic             wb_i,
  output logic [CNT_W-1:0] hit_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o,
  output logic [CNT_W-1:0] wb_cnt_o
);

  logic [CNT_W-1:0] hit_q, miss_q, wb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= '0;
      miss_q <= '0;
      wb_q   <= '0;
    end else begin
      if (hit_i)  hit_q  <= CNT_W'(hit_q + 1'b1);
      if (miss_i) miss_q <= CNT_W'(miss_q + 1'b1);
      if (wb_i)   wb_q   <= CNT_W'(wb_q + 1'b1);
    end
  end

  assign hit_cnt_o  = hit_q;
  assign miss_cnt_o = miss_q;
  assign wb_cnt_o   = wb_q;

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller FSM.
// Ports: clk, rst_n (async active-low); cpu_req/cpu_res CPU side;
// mem_req/mem_data main memory side (mem_req registered); tag_req/tag_write/
// tag_read and data_req/data_write/data_read drive the single-port arrays;
// mem_err sticky memory timeout flag.
// Optional: define DM_CACHE_STATS_EN to add hit_cnt/miss_cnt/wb_cnt outputs.
// Parameter MEM_TIMEOUT: cycles waiting for mem_data.ready before error (0 = off).
module dm_cache_ctrl
  import cache_def::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  cpu_req_type    cpu_req,
  output cpu_result_type cpu_res,
  output mem_req_type    mem_req,
  input  mem_data_type   mem_data,
  output cache_req_type  tag_req,
  output cache_tag_type  tag_write,
  input  cache_tag_type  tag_read,
  output cache_req_type  data_req,
  output cache_data_type data_write,
  input  cache_data_type data_read,
`ifdef DM_CACHE_STATS_EN
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt,
`endif
  output logic           mem_err
);

  localparam int unsigned TMO_W = 32;

  cache_state_type  state_q, state_d;
  cpu_req_type      req_q, req_d;
  mem_req_type      mem_req_q, mem_req_d;
  logic             mem_err_q, mem_err_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] arr_idx;
  logic             hit;
  logic             tmo_hit;
  logic             unused_bits;

  assign req_tag = req_q.addr[TAGMSB:TAGLSB];
  assign req_idx = req_q.addr[IDX_MSB:IDX_LSB];
  assign hit     = tag_read.valid && (tag_read.tag == req_tag);
  assign tmo_hit = (MEM_TIMEOUT != 0) && (tmo_q == TMO_W'(MEM_TIMEOUT - 1));
  assign unused_bits = ^{req_q.addr[1:0], req_q.valid};

  // State, latched request, memory request and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      mem_req_q <= '0;
      mem_err_q <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      mem_req_q <= mem_req_d;
      mem_err_q <= mem_err_d;
      tmo_q     <= tmo_d;
    end
  end

  // Next-state, memory request and array/CPU strobes.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    mem_req_d  = mem_req_q;
    mem_err_d  = mem_err_q;
    arr_idx    = req_idx;
    cpu_res    = '0;
    tag_req    = '0;
    data_req   = '0;
    tag_write  = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
    data_write = data_read;

    unique case (state_q)
      IDLE: begin
        // Arrays are addressed straight from the CPU so the lookup is ready next cycle.
        arr_idx = cpu_req.addr[IDX_MSB:IDX_LSB];
        if (cpu_req.valid) begin
          req_d   = cpu_req;
          state_d = COMPARE_TAG;
        end
      end
      COMPARE_TAG: begin
        if (hit) begin
          cpu_res.ready = 1'b1;
          cpu_res.data  = get_word(data_read, req_q.addr[3:2]);
          if (req_q.rw) begin
            tag_req.we      = 1'b1;
            tag_write.dirty = 1'b1;
            data_req.we     = 1'b1;
            data_write      = put_word(data_read, req_q.addr[3:2], req_q.data);
          end
          state_d = IDLE;
        end else if (tag_read.valid && tag_read.dirty) begin
          mem_req_d = '{addr: {tag_read.tag, req_idx, 4'b0}, data: data_read, rw: 1'b1, valid: 1'b1};
          state_d   = WRITE_BACK;
        end else begin
          mem_req_d = '{addr: {req_tag, req_idx, 4'b0}, data: '0, rw: 1'b0, valid: 1'b1};
          state_d   = ALLOCATE;
        end
      end
      WRITE_BACK: begin
        if (mem_data.ready) begin
          mem_req_d = '{addr: {req_tag, req_idx, 4'b0}, data: '0, rw: 1'b0, valid: 1'b1};
          state_d   = ALLOCATE;
        end else if (tmo_hit) begin
          mem_req_d.valid = 1'b0;
          mem_err_d       = 1'b1;
          state_d         = IDLE;
        end
      end
      ALLOCATE: begin
        if (mem_data.ready) begin
          data_req.we     = 1'b1;
          data_write      = mem_data.data;
          tag_req.we      = 1'b1;
          mem_req_d.valid = 1'b0;
          state_d         = COMPARE_TAG;
        end else if (tmo_hit) begin
          mem_req_d.valid = 1'b0;
          mem_err_d       = 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    tag_req.index  = arr_idx;
    data_req.index = arr_idx;
    // Timeout counter restarts on every state change.
    tmo_d = (state_d != state_q) ? '0 : TMO_W'(tmo_q + 1'b1);
  end

  assign mem_req = mem_req_q;
  assign mem_err = mem_err_q;

`ifdef DM_CACHE_STATS_EN
  // Marks the re-compare following a fill so it is not counted as a hit.
  logic refill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) refill_q <= 1'b0;
    else        refill_q <= (state_q == ALLOCATE) && mem_data.ready;
  end

  dm_cache_stats u_stats (
    .clk        (clk),
    .rst_n      (rst_n),
    .hit_i      ((state_q == COMPARE_TAG) && hit && !refill_q),
    .miss_i     ((state_q == COMPARE_TAG) && !hit),
    .wb_i       ((state_q == COMPARE_TAG) && (state_d == WRITE_BACK)),
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt),
    .wb_cnt_o   (wb_cnt)
  );
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl: tag/data array models, a fixed-latency
// memory model, a vector table of CPU transactions and hand-written sequences
// for mid-refill reset and memory timeout.
module tb_dm_cache_ctrl;
  import cache_def::*;

  localparam int unsigned MEM_LAT = 3;
  localparam int unsigned TMO     = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  cpu_req_type    cpu_req = '0;
  cpu_result_type cpu_res;
  mem_req_type    mem_req;
  mem_data_type   mem_data = '0;
  cache_req_type  tag_req, data_req;
  cache_tag_type  tag_write;
  cache_tag_type  tag_read = '0;
  cache_data_type data_write;
  cache_data_type data_read = '0;
  logic           mem_err;
`ifdef DM_CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  cache_tag_type  tag_mem  [1024] = '{default: '0};
  cache_data_type data_mem [1024] = '{default: '0};

  int checks = 0;
  int errors = 0;

  logic           mem_hold = 1'b0;
  int unsigned    mcnt = 0;
  int             tx_n = 0;
  logic [31:0]    tx_addr [64];
  logic           tx_rw   [64];
  cache_data_type tx_data [64];

  always #5 clk = ~clk;

  dm_cache_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_res    (cpu_res),
    .mem_req    (mem_req),
    .mem_data   (mem_data),
    .tag_req    (tag_req),
    .tag_write  (tag_write),
    .tag_read   (tag_read),
    .data_req   (data_req),
    .data_write (data_write),
    .data_read  (data_read),
`ifdef DM_CACHE_STATS_EN
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
    .wb_cnt     (wb_cnt),
`endif
    .mem_err    (mem_err)
  );

  // Array writes on the clock edge.
  always @(posedge clk) begin
    if (tag_req.we)  tag_mem[tag_req.index]   <= tag_write;
    if (data_req.we) data_mem[data_req.index] <= data_write;
  end

  // Array read port, settled well before the next edge.
  always @(posedge clk) begin
    #2;
    tag_read  = tag_mem[tag_req.index];
    data_read = data_mem[data_req.index];
  end

  function automatic cache_data_type line_for(input logic [31:0] a);
    cache_data_type l;
    if (a == 32'h10) l = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    else for (int i = 0; i < 4; i++) l[32*i +: 32] = {4'(i + 5), a[27:0]};
    return l;
  endfunction

  // Memory: ready MEM_LAT cycles after a request appears, one cycle wide.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_data = '0;
      mcnt     = 0;
    end else begin
      if (mem_data.ready && mem_req.valid && tx_n < 64) begin
        tx_addr[tx_n] = mem_req.addr;
        tx_rw[tx_n]   = mem_req.rw;
        tx_data[tx_n] = mem_req.data;
        tx_n++;
      end
      #1;
      if (mem_data.ready) begin
        mem_data.ready = 1'b0;
        mcnt = 0;
      end
      if (mem_req.valid && !mem_hold) begin
        mcnt++;
        if (mcnt == MEM_LAT) begin
          mem_data.ready = 1'b1;
          mem_data.data  = line_for(mem_req.addr);
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One CPU transaction; lat counts the accept cycle as 1, -1 if no ready.
  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic rw,
                        output logic [31:0] rdata, output int lat);
    logic got;
    @(posedge clk); #1;
    cpu_req = '{addr: a, data: d, rw: rw, valid: 1'b1};
    @(posedge clk); #1;
    cpu_req = '{addr: 32'hFFFF_FFFF, data: 32'h0, rw: 1'b0, valid: 1'b0};
    lat   = 2;
    got   = 1'b0;
    rdata = '0;
    while (!got && lat < 60) begin
      @(negedge clk);
      if (cpu_res.ready) begin
        got   = 1'b1;
        rdata = cpu_res.data;
      end else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    if (!got) lat = -1;
  endtask

  typedef struct {
    logic [31:0]    addr;
    logic [31:0]    wdata;
    logic           rw;
    logic [31:0]    exp_data;
    int             exp_lat;
    int             exp_ntx;
    logic [31:0]    tx0_addr;
    logic           tx0_rw;
    logic           chk_tx0_data;
    cache_data_type tx0_data;
    logic [31:0]    tx1_addr;
    logic [19:0]    exp_tag;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0] rdata;
    int          lat;
    int          base;
    int          k;
    logic        seen_rdy;

    vecs[0] = '{32'h0000_0014, 32'h0, 1'b0, 32'h2222_2222, 6, 1, 32'h10, 1'b0, 1'b0, '0, 32'h0, 20'h80000};
    vecs[1] = '{32'h0000_0014, 32'hDEAD_BEEF, 1'b1, 32'h0, 2, 0, 32'h0, 1'b0, 1'b0, '0, 32'h0, 20'hC0000};
    vecs[2] = '{32'h0000_0014, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 0, 32'h0, 1'b0, 1'b0, '0, 32'h0, 20'hC0000};
    vecs[3] = '{32'h0000_4014, 32'h0, 1'b0, 32'h6000_4010, 9, 2, 32'h10, 1'b1, 1'b1,
                128'h4444_4444_3333_3333_DEAD_BEEF_1111_1111, 32'h4010, 20'h80001};
    vecs[4] = '{32'h0000_4018, 32'h0, 1'b0, 32'h7000_4010, 2, 0, 32'h0, 1'b0, 1'b0, '0, 32'h0, 20'h80001};
    vecs[5] = '{32'h0000_0120, 32'h1234_5678, 1'b1, 32'h0, 6, 1, 32'h120, 1'b0, 1'b0, '0, 32'h0, 20'hC0000};
    vecs[6] = '{32'h0000_0120, 32'h0, 1'b0, 32'h1234_5678, 2, 0, 32'h0, 1'b0, 1'b0, '0, 32'h0, 20'hC0000};
    vecs[7] = '{32'h0000_012C, 32'h0, 1'b0, 32'h8000_0120, 2, 0, 32'h0, 1'b0, 1'b0, '0, 32'h0, 20'hC0000};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_mem_req", 128'(mem_req), 128'(0));
    check("rst_cpu_res", 128'(cpu_res), 128'(0));
    check("rst_mem_err", 128'(mem_err), 128'(0));
    check("rst_we", 128'({tag_req.we, data_req.we}), 128'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      base = tx_n;
      do_req(vecs[i].addr, vecs[i].wdata, vecs[i].rw, rdata, lat);
      check($sformatf("v%0d_lat", i), 128'(lat), 128'(vecs[i].exp_lat));
      if (!vecs[i].rw) check($sformatf("v%0d_data", i), 128'(rdata), 128'(vecs[i].exp_data));
      check($sformatf("v%0d_ntx", i), 128'(tx_n - base), 128'(vecs[i].exp_ntx));
      if (vecs[i].exp_ntx > 0) begin
        check($sformatf("v%0d_tx0_addr", i), 128'(tx_addr[base]), 128'(vecs[i].tx0_addr));
        check($sformatf("v%0d_tx0_rw", i), 128'(tx_rw[base]), 128'(vecs[i].tx0_rw));
      end
      if (vecs[i].chk_tx0_data) check($sformatf("v%0d_tx0_data", i), tx_data[base], vecs[i].tx0_data);
      if (vecs[i].exp_ntx > 1) begin
        check($sformatf("v%0d_tx1_addr", i), 128'(tx_addr[base+1]), 128'(vecs[i].tx1_addr));
        check($sformatf("v%0d_tx1_rw", i), 128'(tx_rw[base+1]), 128'(0));
      end
      @(negedge clk);
      check($sformatf("v%0d_tag", i), 128'(tag_mem[vecs[i].addr[13:4]]), 128'(vecs[i].exp_tag));
`ifdef DM_CACHE_STATS_EN
      if (i == 3) begin
        check("stats_hit", 128'(hit_cnt), 128'(2));
        check("stats_miss", 128'(miss_cnt), 128'(2));
        check("stats_wb", 128'(wb_cnt), 128'(1));
      end
`endif
    end

    // Asynchronous reset during a refill.
    @(posedge clk); #1;
    cpu_req = '{addr: 32'h0000_8014, data: 32'h0, rw: 1'b0, valid: 1'b1};
    @(posedge clk); #1;
    cpu_req = '0;
    @(posedge clk); #3;
    check("alloc_valid", 128'(mem_req.valid), 128'(1));
    check("alloc_addr", 128'(mem_req.addr), 128'(32'h8010));
    rst_n = 1'b0;
    #1;
    check("arst_valid", 128'(mem_req.valid), 128'(0));
    check("arst_ready", 128'(cpu_res.ready), 128'(0));
    check("arst_tag1", 128'(tag_mem[1]), 128'(20'h80001));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_res.ready || mem_req.valid) seen_rdy = 1'b1;
    end
    check("post_rst_idle", 128'(seen_rdy), 128'(0));
    check("post_rst_tag1", 128'(tag_mem[1]), 128'(20'h80001));

    // Memory never answers: timeout after TMO cycles in ALLOCATE.
    mem_hold = 1'b1;
    @(posedge clk); #1;
    cpu_req = '{addr: 32'h0000_C020, data: 32'h0, rw: 1'b0, valid: 1'b1};
    @(posedge clk); #1;
    cpu_req = '0;
    k = 2;
    seen_rdy = 1'b0;
    while (!mem_err && k < 60) begin
      @(negedge clk);
      if (cpu_res.ready) seen_rdy = 1'b1;
      if (!mem_err) begin
        @(posedge clk); #1;
        k++;
      end
    end
    check("tmo_cycle", 128'(k), 128'(2 + TMO + 1));
    check("tmo_valid", 128'(mem_req.valid), 128'(0));
    check("tmo_no_ready", 128'(seen_rdy), 128'(0));
    check("tmo_tag2", 128'(tag_mem[2]), 128'(0));
    mem_hold = 1'b0;

    base = tx_n;
    do_req(32'h0000_4014, 32'h0, 1'b0, rdata, lat);
    check("tmo_hit_lat", 128'(lat), 128'(2));
    check("tmo_hit_data", 128'(rdata), 128'(32'h6000_4010));
    check("tmo_hit_ntx", 128'(tx_n - base), 128'(0));
    check("mem_err_sticky", 128'(mem_err), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
